// File: rtl/bus_slave_ram_pkg.sv
// Shared bus widths, encodings and FSM state type for the bus_slave_ram responder.
package bus_slave_ram_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int WAIT_CNT_W  = 4;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_slave_ram_if.sv
// Bus signals between a CPU bus master and the bus_slave_ram responder.
interface bus_slave_ram_if;
    import bus_slave_ram_pkg::*;

    logic                   cs_;
    logic                   as_;
    logic                   rw;
    logic [WORD_ADDR_W-1:0] addr;
    logic [WORD_DATA_W-1:0] wr_data;
    logic [WORD_DATA_W-1:0] rd_data;
    logic                   rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );

endinterface

// File: rtl/bus_slave_ram_mem.sv
// Single-port synchronous scratch RAM: one registered read or one write per enabled cycle.
module bus_slave_ram_mem
    import bus_slave_ram_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WORD_DATA_W-1:0] wdata,
    output logic [WORD_DATA_W-1:0] rdata
);

    logic [WORD_DATA_W-1:0] ram_q [DEPTH];

    // Contents survive reset, so neither the array nor the read register has one.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                ram_q[addr] <= wdata;
            end else begin
                rdata <= ram_q[addr];
            end
        end
    end

endmodule

// File: rtl/bus_slave_ram.sv
// Bus responder with a fixed number of wait states and a one-cycle active-low ready pulse,
// backed by a DEPTH-word scratch RAM.
module bus_slave_ram
    import bus_slave_ram_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    bus_slave_ram_if.slave   bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic                   rw_q, rw_d;
    logic [WORD_DATA_W-1:0] wdata_q, wdata_d;
    logic                   rdy_q, rdy_d;

    logic                   mem_en;
    logic                   mem_we;
    logic [WORD_DATA_W-1:0] mem_rdata;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[WORD_ADDR_W-1:ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.cs_ == ENABLE_ && bus.as_ == ENABLE_) begin
                    idx_d   = bus.addr[ADDR_W-1:0];
                    rw_d    = bus.rw;
                    wdata_d = bus.wr_data;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == ACK) ? ENABLE_ : DISABLE_;
        // The _d request fields equal the live bus on a zero-wait acceptance and the
        // latched copy otherwise, so the RAM access on ACK entry works for both.
        // Gating with reset keeps a held-in-reset edge from touching the RAM.
        mem_en = reset && (state_d == ACK);
        mem_we = (rw_d == WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= WRITE;
            wdata_q <= '0;
            rdy_q   <= DISABLE_;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
        end
    end

    bus_slave_ram_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (idx_d),
        .wdata (wdata_d),
        .rdata (mem_rdata)
    );

    // Zero outside a read ACK so several slaves can be OR-combined onto one bus.
    assign bus.rd_data = (state_q == ACK && rw_q == READ) ? mem_rdata : '0;
    assign bus.rdy_    = rdy_q;

endmodule

// File: tb/tb_bus_slave_ram.sv
// Scoreboard bench for bus_slave_ram: one instance with two wait states, one with none.
module tb_bus_slave_ram;
    import bus_slave_ram_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t q2[$];
    exp_t q0[$];

    bus_slave_ram_if bus2();
    bus_slave_ram_if bus0();

    bus_slave_ram #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );
    bus_slave_ram #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    always #5 clk = ~clk;
    // cyc counts rising edges; the cycle after edge n carries cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            n_vec++;
            if (bus2.rdy_ === ENABLE_) begin
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL w2_unexpected_rdy: rdy_=0 rd_data=%h at cyc %0d, no request pending", bus2.rd_data, cyc);
                end else begin
                    e = q2.pop_front();
                    if (bus2.rd_data !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL w2_ack: got rd_data=%h cyc=%0d, want rd_data=%h cyc=%0d", bus2.rd_data, cyc, e.data, e.cyc);
                    end
                end
            end else if (bus2.rdy_ !== DISABLE_ || bus2.rd_data !== 32'h0) begin
                n_err++;
                $display("FAIL w2_idle: got rdy_=%b rd_data=%h, want rdy_=1 rd_data=0 at cyc %0d", bus2.rdy_, bus2.rd_data, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            n_vec++;
            if (bus0.rdy_ === ENABLE_) begin
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL w0_unexpected_rdy: rdy_=0 rd_data=%h at cyc %0d, no request pending", bus0.rd_data, cyc);
                end else begin
                    e = q0.pop_front();
                    if (bus0.rd_data !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL w0_ack: got rd_data=%h cyc=%0d, want rd_data=%h cyc=%0d", bus0.rd_data, cyc, e.data, e.cyc);
                    end
                end
            end else if (bus0.rdy_ !== DISABLE_ || bus0.rd_data !== 32'h0) begin
                n_err++;
                $display("FAIL w0_idle: got rdy_=%b rd_data=%h, want rdy_=1 rd_data=0 at cyc %0d", bus0.rdy_, bus0.rd_data, cyc);
            end
        end
    end

    task automatic drive2(input logic c, input logic a, input logic r, input logic [29:0] ad, input logic [31:0] d);
        bus2.cs_ = c; bus2.as_ = a; bus2.rw = r; bus2.addr = ad; bus2.wr_data = d;
    endtask

    task automatic drive0(input logic c, input logic a, input logic r, input logic [29:0] ad, input logic [31:0] d);
        bus0.cs_ = c; bus0.as_ = a; bus0.rw = r; bus0.addr = ad; bus0.wr_data = d;
    endtask

    // One full transaction on the two-wait-state instance; ready is due 2 edges after acceptance.
    task automatic txn2(input logic r, input logic [29:0] ad, input logic [31:0] d, input logic [31:0] exp_data);
        exp_t e;
        drive2(ENABLE_, ENABLE_, r, ad, d);
        @(posedge clk); #1;
        e.data = exp_data;
        e.cyc  = cyc + 2;
        q2.push_back(e);
        drive2(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   acc;
        drive2(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        drive0(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        #2 reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Deselected strobe held for 10 cycles: nothing may respond.
        drive2(DISABLE_, ENABLE_, WRITE, 30'h5, 32'hFFFF_FFFF);
        drive0(DISABLE_, ENABLE_, WRITE, 30'h5, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #1;
        drive2(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        drive0(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);

        txn2(WRITE, 30'h05, 32'hDEAD_BEEF, 32'h0);
        txn2(READ,  30'h05, 32'h0,         32'hDEAD_BEEF);

        // Zero wait states, write then read accepted in the IDLE right after ACK.
        drive0(ENABLE_, ENABLE_, WRITE, 30'h10, 32'h1234_5678);
        @(posedge clk); #1;
        acc = cyc;
        e.data = 32'h0; e.cyc = acc; q0.push_back(e);
        drive0(ENABLE_, ENABLE_, READ, 30'h10, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        e.data = 32'h1234_5678; e.cyc = acc + 2; q0.push_back(e);
        drive0(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        txn2(WRITE, 30'h105, 32'hA5A5_A5A5, 32'h0);
        txn2(READ,  30'h005, 32'h0,         32'hA5A5_A5A5);

        // Strobe released during WAIT (txn2 drops cs_/as_ right after acceptance).
        txn2(WRITE, 30'h20, 32'h1111_1111, 32'h0);
        txn2(READ,  30'h20, 32'h0,         32'h1111_1111);

        // Reset during WAIT drops the pending write to 0x21.
        txn2(WRITE, 30'h21, 32'h0BAD_F00D, 32'h0);
        drive2(ENABLE_, ENABLE_, WRITE, 30'h21, 32'h2222_2222);
        @(posedge clk); #1;
        drive2(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus2.rdy_ !== DISABLE_ || bus2.rd_data !== 32'h0 || u_dut2.state_q != IDLE) begin
            n_err++;
            $display("FAIL reset_in_wait: got rdy_=%b rd_data=%h state=%0d, want rdy_=1 rd_data=0 state=IDLE",
                     bus2.rdy_, bus2.rd_data, u_dut2.state_q);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        txn2(READ, 30'h21, 32'h0, 32'h0BAD_F00D);

        // Write with cs_ deasserted must not reach the RAM.
        txn2(WRITE, 30'h30, 32'h3030_3030, 32'h0);
        drive2(DISABLE_, ENABLE_, WRITE, 30'h30, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        drive2(DISABLE_, DISABLE_, READ, 30'h0, 32'h0);
        txn2(READ, 30'h30, 32'h0, 32'h3030_3030);

        for (int i = 0; i < 50 && (q0.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        #1;
        n_vec++;
        if (q0.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d responses outstanding, want 0/0", q2.size(), q0.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
